// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command handshake between a host and the ALU sequencer.
interface alu_op_sequencer_if #(parameter int REPW = 4);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [2:0]      cmd_opc;
   logic [1:0]      cmd_rd;
   logic [1:0]      cmd_ra;
   logic [1:0]      cmd_rb;
   logic            cmd_cin;
   logic [REPW-1:0] cmd_rep;
   modport master (output cmd_valid, cmd_opc, cmd_rd, cmd_ra, cmd_rb, cmd_cin, cmd_rep, input cmd_ready);
   modport slave (input cmd_valid, cmd_opc, cmd_rd, cmd_ra, cmd_rb, cmd_cin, cmd_rep, output cmd_ready);
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: owns a small register file and drives an external ALU,
// repeating each command's operation back-to-back with write-back every cycle.
module alu_op_sequencer #(
   parameter int DW   = 16,
   parameter int NREG = 4,
   parameter int REPW = 4
) (
   input  logic          clk,
   input  logic          rst,
   alu_op_sequencer_if.slave cmd,
   input  logic          ld_en,
   input  logic [1:0]    ld_sel,
   input  logic [DW-1:0] ld_data,
   input  logic [1:0]    rd_sel,
   output logic [DW-1:0] rd_data,
   output logic [DW-1:0] alu_inpA,
   output logic [DW-1:0] alu_inpB,
   output logic          alu_inpC,
   output logic [2:0]    alu_opc,
   input  logic [DW-1:0] alu_outW,
   input  logic          alu_zero,
   input  logic          alu_neg,
   output logic          busy,
   output logic          done,
   output logic          flag_zero,
   output logic          flag_neg
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t state, nxt;
   logic [DW-1:0]   regs [NREG];
   logic [2:0]      opc;
   logic [1:0]      rd, ra, rb;
   logic            cin;
   logic [REPW-1:0] cnt;
   logic            idle, exec;
   assign idle    = state == IDLE;
   assign exec    = state == EXEC;
   assign rd_data = regs[rd_sel];
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= nxt;
   always_comb
      nxt = idle ? (cmd.cmd_valid ? EXEC : IDLE) :
            exec ? (cnt == REPW'(1) ? DONE : EXEC) : IDLE;
   always_comb begin
      cmd.cmd_ready = idle;
      busy          = !idle;
      done          = state == DONE;
      alu_inpA      = exec ? regs[ra] : '0;
      alu_inpB      = exec ? regs[rb] : '0;
      alu_inpC      = exec && cin;
      alu_opc       = exec ? opc : 3'd7;
   end
   // Host loads land at the same edge as an acceptance, so EXEC sees them.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         flag_zero <= 1'b0;
         flag_neg  <= 1'b0;
         cnt       <= '0;
         opc       <= '0;
         rd        <= '0;
         ra        <= '0;
         rb        <= '0;
         cin       <= 1'b0;
      end else begin
         if (idle && ld_en) regs[ld_sel] <= ld_data;
         if (idle && cmd.cmd_valid) begin
            opc <= cmd.cmd_opc;
            rd  <= cmd.cmd_rd;
            ra  <= cmd.cmd_ra;
            rb  <= cmd.cmd_rb;
            cin <= cmd.cmd_cin;
            cnt <= cmd.cmd_rep == '0 ? REPW'(1) : cmd.cmd_rep;
         end
         if (exec) begin
            regs[rd]  <= alu_outW;
            flag_zero <= alu_zero;
            flag_neg  <= alu_neg;
            cnt       <= cnt - REPW'(1);
         end
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed plus random commands against a register-file
// model; the bench also plays the role of the combinational ALU.
module tb_alu_op_sequencer;
   logic        clk, rst;
   logic        ld_en;
   logic [1:0]  ld_sel, rd_sel;
   logic [15:0] ld_data, rd_data;
   logic [15:0] alu_inpA, alu_inpB, alu_outW;
   logic        alu_inpC, alu_zero, alu_neg;
   logic [2:0]  alu_opc;
   logic        busy, done, flag_zero, flag_neg;
   int          total = 0, bad = 0;
   logic [15:0] m [4];
   logic        mz, mn;
   logic [2:0]  c_opc;
   logic [1:0]  c_rd, c_ra, c_rb;
   logic        c_cin;
   logic [3:0]  c_rep;

   alu_op_sequencer_if #(.REPW(4)) cif ();

   alu_op_sequencer #(.DW(16), .NREG(4), .REPW(4)) dut (
      .clk(clk), .rst(rst), .cmd(cif),
      .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
      .rd_sel(rd_sel), .rd_data(rd_data),
      .alu_inpA(alu_inpA), .alu_inpB(alu_inpB), .alu_inpC(alu_inpC), .alu_opc(alu_opc),
      .alu_outW(alu_outW), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .busy(busy), .done(done), .flag_zero(flag_zero), .flag_neg(flag_neg)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [15:0] alu_ref(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic c);
      case (o)
         3'd0:    return 16'd0 - a;
         3'd1:    return a + 16'd1;
         3'd2:    return a + b + {15'd0, c};
         3'd3:    return a - b;
         3'd4:    return a & b;
         3'd5:    return a | b;
         3'd6:    return a ^ b;
         default: return 16'd0;
      endcase
   endfunction

   always_comb begin
      alu_outW = alu_ref(alu_opc, alu_inpA, alu_inpB, alu_inpC);
      alu_zero = alu_outW == 16'd0;
      alu_neg  = alu_outW[15];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         rd_sel = 2'(i);
         #1;
         chk($sformatf("%s_r%0d", tag, i), rd_data, m[i]);
      end
   endtask

   task automatic load(input logic [1:0] s, input logic [15:0] d);
      ld_en = 1'b1; ld_sel = s; ld_data = d;
      tick();
      ld_en = 1'b0;
      m[s] = d;
   endtask

   task automatic start_cmd(input logic [2:0] o, input logic [1:0] d, input logic [1:0] a, input logic [1:0] b, input logic c, input logic [3:0] r);
      cif.cmd_opc = o; cif.cmd_rd = d; cif.cmd_ra = a; cif.cmd_rb = b; cif.cmd_cin = c; cif.cmd_rep = r;
      cif.cmd_valid = 1'b1;
      chk("ready_before_accept", cif.cmd_ready, 1'b1);
      tick();
      cif.cmd_valid = 1'b0;
      c_opc = o; c_rd = d; c_ra = a; c_rb = b; c_cin = c; c_rep = r;
   endtask

   // Runs the EXEC iterations and the DONE cycle of the command held in c_*.
   task automatic exec_cmd(input string tag);
      int n;
      logic [15:0] r;
      n = (c_rep == 4'd0) ? 1 : int'(c_rep);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_busy"}, busy, 1'b1);
         chk({tag, "_nodone"}, done, 1'b0);
         chk({tag, "_noready"}, cif.cmd_ready, 1'b0);
         chk({tag, "_opc"}, alu_opc, c_opc);
         chk({tag, "_inpA"}, alu_inpA, m[c_ra]);
         chk({tag, "_inpB"}, alu_inpB, m[c_rb]);
         chk({tag, "_inpC"}, alu_inpC, c_cin);
         r = alu_ref(c_opc, m[c_ra], m[c_rb], c_cin);
         m[c_rd] = r;
         mz = r == 16'd0;
         mn = r[15];
         tick();
      end
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_done_busy"}, busy, 1'b1);
      chk({tag, "_fz"}, flag_zero, mz);
      chk({tag, "_fn"}, flag_neg, mn);
      check_regs(tag);
      tick();
      chk({tag, "_done_gone"}, done, 1'b0);
      chk({tag, "_idle_busy"}, busy, 1'b0);
      chk({tag, "_park_opc"}, alu_opc, 3'd7);
      chk({tag, "_park_A"}, alu_inpA, 16'd0);
   endtask

   initial begin
      rst = 1'b1; ld_en = 1'b0; ld_sel = '0; ld_data = '0; rd_sel = '0;
      cif.cmd_valid = 1'b0; cif.cmd_opc = '0; cif.cmd_rd = '0; cif.cmd_ra = '0;
      cif.cmd_rb = '0; cif.cmd_cin = 1'b0; cif.cmd_rep = '0;
      for (int i = 0; i < 4; i++) m[i] = 16'd0;
      mz = 1'b0; mn = 1'b0;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_ready", cif.cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_fz", flag_zero, 1'b0);
      chk("rst_fn", flag_neg, 1'b0);
      chk("rst_park_opc", alu_opc, 3'd7);
      chk("rst_park_B", alu_inpB, 16'd0);
      chk("rst_park_C", alu_inpC, 1'b0);
      check_regs("rst");

      load(2'd0, 16'h0005);
      start_cmd(3'd1, 2'd0, 2'd0, 2'd0, 1'b0, 4'd3);
      exec_cmd("inc3");
      chk("inc3_r0", m[0], 16'h0008);

      load(2'd1, 16'h0001);
      start_cmd(3'd0, 2'd2, 2'd1, 2'd0, 1'b0, 4'd0);
      exec_cmd("neg_rep0");
      chk("neg_rep0_fn", flag_neg, 1'b1);

      load(2'd0, 16'h7FFF);
      load(2'd1, 16'h0001);
      start_cmd(3'd2, 2'd3, 2'd0, 2'd1, 1'b1, 4'd1);
      exec_cmd("addc");
      rd_sel = 2'd3; #1;
      chk("addc_r3", rd_data, 16'h8001);

      load(2'd0, 16'h00F0);
      load(2'd1, 16'h0F00);
      start_cmd(3'd4, 2'd0, 2'd0, 2'd1, 1'b0, 4'd1);
      exec_cmd("and0");
      chk("and0_fz", flag_zero, 1'b1);

      start_cmd(3'd7, 2'd1, 2'd2, 2'd3, 1'b0, 4'd2);
      exec_cmd("opc7");

      load(2'd0, 16'h0000);
      start_cmd(3'd1, 2'd0, 2'd0, 2'd0, 1'b0, 4'd15);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m[i] = 16'd0;
      mz = 1'b0; mn = 1'b0;
      chk("abort_done", done, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_fz", flag_zero, 1'b0);
      chk("abort_fn", flag_neg, 1'b0);
      check_regs("abort");
      chk("abort_ready", cif.cmd_ready, 1'b1);
      tick();
      chk("abort_done2", done, 1'b0);

      // Command and load held across a running command; both wait for IDLE.
      load(2'd2, 16'h0010);
      start_cmd(3'd1, 2'd2, 2'd2, 2'd0, 1'b0, 4'd2);
      cif.cmd_opc = 3'd6; cif.cmd_rd = 2'd1; cif.cmd_ra = 2'd3; cif.cmd_rb = 2'd2;
      cif.cmd_cin = 1'b0; cif.cmd_rep = 4'd1; cif.cmd_valid = 1'b1;
      ld_en = 1'b1; ld_sel = 2'd3; ld_data = 16'h1234;
      exec_cmd("hold_a");
      chk("hold_ready", cif.cmd_ready, 1'b1);
      tick();
      cif.cmd_valid = 1'b0; ld_en = 1'b0;
      m[3] = 16'h1234;
      c_opc = 3'd6; c_rd = 2'd1; c_ra = 2'd3; c_rb = 2'd2; c_cin = 1'b0; c_rep = 4'd1;
      exec_cmd("hold_b");

      for (int k = 0; k < 12; k++) begin
         load(2'($urandom_range(0, 3)), 16'($urandom));
         load(2'($urandom_range(0, 3)), 16'($urandom));
         start_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)));
         exec_cmd($sformatf("rnd%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
